msrv32_instr_queue_mux: RTL
===========================

// Module: msrv32_instr_queue_mux
// PURPOSE
//  Parametrised instruction queue and field-split stage between fetch and decode.
//  - Buffers up to DEPTH {pc, instr} pairs with valid/ready handshakes on both sides.
//  - Slices the head entry into opcode/funct/register/CSR fields.
//  - Flush drains the queue in one cycle and forces NOP fields onto the decode side.
// PARAMETERS
//  DEPTH   4             queue entries; power of 2, >=2
//  XLEN    32            PC width carried alongside each instruction
//  NOP     32'h00000013  instruction presented when empty or flushing (addi x0,x0,0)
// PORTS
//  ms_riscv32_mp_clk_in    in   1             clock; all state on rising edge
//  ms_riscv32_mp_rst_n_in  in   1             asynchronous, active-low reset
//  flush_in                in   1             pipeline flush (branch/trap redirect)
//  instr_in                in   32            fetched instruction
//  pc_in                   in   XLEN          PC of instr_in
//  instr_valid_in          in   1             fetch offers instr_in/pc_in
//  instr_ready_out         out  1             queue can accept (= !full)
//  dec_valid_out           out  1             head entry valid for decode
//  dec_ready_in            in   1             decode consumes head
//  pc_out                  out  XLEN          PC of head entry
//  opcode_out              out  7             head[6:0]
//  rdaddr_out              out  5             head[11:7]
//  funct3_out              out  3             head[14:12]
//  rs1addr_out             out  5             head[19:15]
//  rs2addr_out             out  5             head[24:20]
//  funct7_out              out  7             head[31:25]
//  csr_addr_out            out  12            head[31:20]
//  instr_out               out  [31:7]        head[31:7]
//  count_out               out  $clog2(DEPTH+1)  current occupancy
// BEHAVIOUR
//  - Reset (async assert, sync release): wr/rd pointers = 0, count = 0; storage is not
//    cleared. While count = 0: dec_valid_out = 0, instr_ready_out = 1, fields decode NOP,
//    pc_out = 0.
//  - Enqueue on edge when instr_valid_in & instr_ready_out & !flush_in: write at wr_ptr,
//    wr_ptr++ (mod DEPTH).
//  - Dequeue on edge when dec_valid_out & dec_ready_in & !flush_in: rd_ptr++ (mod DEPTH).
//  - Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
//  - Full (count = DEPTH): instr_ready_out = 0, even if dec_ready_in is high in the same
//    cycle. There is no full-bypass.
//  - Empty: no fetch-to-decode bypass. The minimum latency is 1 cycle, instr_in -> dec_valid_out.
//  - Outputs are combinational from the head entry. They hold stable while
//    dec_valid_out & !dec_ready_in (AXI-style: valid never drops without a consume or flush).
//  - flush_in = 1:
//    - combinationally: dec_valid_out = 0, fields = NOP, pc_out = 0, instr_ready_out = 0;
//    - on the edge: pointers and count cleared.
//    - Flush has priority over an enqueue or dequeue in the same cycle; both are discarded.
//  - Pointers are $clog2(DEPTH) bits and wrap naturally. count_out is tracked separately
//    and is never derived from the pointers.
//  - Reset asserted mid-transfer: queue contents are lost. Outputs reach reset values
//    immediately, without waiting for a clock.
// STRUCTURE
//  - msrv32_pkg holds:
//    - the NOP constant;
//    - field LSB/MSB localparams (OPCODE, RD, FUNCT3, RS1, RS2, FUNCT7, CSR);
//    - the opcode enum shared with the decoder.
//  - Sub-module msrv32_instr_field_split: purely combinational.
//    - Input: 32-bit instruction plus a force_nop control.
//    - Output: the eight field ports.
//    - Reused by the decode stage.
//  - Top level contains the storage array, the pointers, the count and the handshake logic.
// TESTING
//  1. Reset, then push 32'h12345678 @pc 0x100 with dec_ready_in=0.
//     -> Next cycle: dec_valid_out=1, opcode=7'b1111000, rd=5'h0C, funct3=3'b101,
//        rs1=5'h08, rs2=5'h03, funct7=7'h09, csr=12'h123.
//  2. Push 4 entries with dec_ready_in=0 (DEPTH=4).
//     -> count_out=4, instr_ready_out=0. A 5th push is ignored. Drain order matches push order.
//  3. Queue holds 3 entries; assert flush_in with instr_valid_in=1 for 32'hABCDEF01.
//     -> Same cycle: fields=NOP, dec_valid_out=0.
//     -> Next cycle: count_out=0 and 32'hABCDEF01 is not queued.
//  4. Steady push and pop every cycle for 20 cycles.
//     -> count_out stays constant, pointers wrap, and the output PC sequence equals the
//        input PC sequence.
//  5. Assert rst_n low mid-stream (between clock edges) with 2 entries queued.
//     -> Immediately: dec_valid_out=0, count_out=0, opcode_out=7'h13.
//  6. Hold dec_ready_in=0 for 5 cycles with a valid head.
//     -> All output fields and pc_out stay unchanged until consumed.

Source files
------------

// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared instruction constants, field positions and opcode enum
package msrv32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;
    localparam int CSR_LSB    = 20;
    localparam int CSR_MSB    = 31;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_FENCE  = 7'b0001111,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

endpackage

// File: rtl/msrv32_instr_queue_mux_if.sv
// rtl/msrv32_instr_queue_mux_if.sv - fetch-side and decode-side handshake bundle
interface msrv32_instr_queue_mux_if #(
    parameter int XLEN = 32,
    parameter int CW   = 3
);
    logic [31:0]     instr_in;
    logic [XLEN-1:0] pc_in;
    logic            instr_valid_in;
    logic            instr_ready_out;
    logic            dec_valid_out;
    logic            dec_ready_in;
    logic [XLEN-1:0] pc_out;
    logic [6:0]      opcode_out;
    logic [4:0]      rdaddr_out;
    logic [2:0]      funct3_out;
    logic [4:0]      rs1addr_out;
    logic [4:0]      rs2addr_out;
    logic [6:0]      funct7_out;
    logic [11:0]     csr_addr_out;
    logic [31:7]     instr_out;
    logic [CW-1:0]   count_out;

    modport master (
        output instr_in, pc_in, instr_valid_in, dec_ready_in,
        input  instr_ready_out, dec_valid_out, pc_out, opcode_out, rdaddr_out,
               funct3_out, rs1addr_out, rs2addr_out, funct7_out, csr_addr_out,
               instr_out, count_out
    );

    modport slave (
        input  instr_in, pc_in, instr_valid_in, dec_ready_in,
        output instr_ready_out, dec_valid_out, pc_out, opcode_out, rdaddr_out,
               funct3_out, rs1addr_out, rs2addr_out, funct7_out, csr_addr_out,
               instr_out, count_out
    );
endinterface

// File: rtl/msrv32_instr_field_split.sv
// rtl/msrv32_instr_field_split.sv - combinational slicing of an instruction into fields
module msrv32_instr_field_split
    import msrv32_pkg::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic [31:0] instr_in,
    input  logic        force_nop_in,
    output logic [6:0]  opcode_out,
    output logic [4:0]  rdaddr_out,
    output logic [2:0]  funct3_out,
    output logic [4:0]  rs1addr_out,
    output logic [4:0]  rs2addr_out,
    output logic [6:0]  funct7_out,
    output logic [11:0] csr_addr_out,
    output logic [31:7] instr_out
);
    logic [31:0] sel;

    // Substitute the NOP so decode sees a harmless instruction when nothing is valid
    always_comb begin
        sel          = force_nop_in ? NOP : instr_in;
        opcode_out   = sel[OPCODE_MSB:OPCODE_LSB];
        rdaddr_out   = sel[RD_MSB:RD_LSB];
        funct3_out   = sel[FUNCT3_MSB:FUNCT3_LSB];
        rs1addr_out  = sel[RS1_MSB:RS1_LSB];
        rs2addr_out  = sel[RS2_MSB:RS2_LSB];
        funct7_out   = sel[FUNCT7_MSB:FUNCT7_LSB];
        csr_addr_out = sel[CSR_MSB:CSR_LSB];
        instr_out    = sel[31:7];
    end
endmodule

// File: rtl/msrv32_instr_queue_mux.sv
// rtl/msrv32_instr_queue_mux.sv - fetch-to-decode instruction queue with field split
module msrv32_instr_queue_mux
    import msrv32_pkg::*;
#(
    parameter int          DEPTH = 4,
    parameter int          XLEN  = 32,
    parameter logic [31:0] NOP   = NOP_INSTR
) (
    input  logic                     ms_riscv32_mp_clk_in,
    input  logic                     ms_riscv32_mp_rst_n_in,
    input  logic                     flush_in,
    msrv32_instr_queue_mux_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] mem_pc_q    [DEPTH];
    logic [31:0]     mem_instr_q [DEPTH];
    logic            full, empty, head_valid, enq, deq;

    // Handshake qualification; flush masks both sides so nothing moves that cycle
    always_comb begin
        full                = (count_q == CW'(DEPTH));
        empty               = (count_q == '0);
        head_valid          = !empty && !flush_in;
        enq                 = bus.instr_valid_in && !full && !flush_in;
        deq                 = head_valid && bus.dec_ready_in;
        bus.instr_ready_out = !full && !flush_in;
        bus.dec_valid_out   = head_valid;
        bus.pc_out          = head_valid ? mem_pc_q[rd_ptr_q] : '0;
        bus.count_out       = count_q;
    end

    // Pointer and occupancy update; the count is kept independently of the pointers
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; not reset since occupancy alone decides what is valid
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (enq) begin
            mem_pc_q[wr_ptr_q]    <= bus.pc_in;
            mem_instr_q[wr_ptr_q] <= bus.instr_in;
        end
    end

    msrv32_instr_field_split #(.NOP(NOP)) u_field_split (
        .instr_in     (mem_instr_q[rd_ptr_q]),
        .force_nop_in (!head_valid),
        .opcode_out   (bus.opcode_out),
        .rdaddr_out   (bus.rdaddr_out),
        .funct3_out   (bus.funct3_out),
        .rs1addr_out  (bus.rs1addr_out),
        .rs2addr_out  (bus.rs2addr_out),
        .funct7_out   (bus.funct7_out),
        .csr_addr_out (bus.csr_addr_out),
        .instr_out    (bus.instr_out)
    );
endmodule
